uart8_rx_sync: RTL



---
 rtl/uart8_rx_sync_pkg.sv | 27 ++
 rtl/uart8_rx_sync_if.sv | 23 ++
 rtl/uart8_rx_sync_tick_gen.sv | 26 ++
 rtl/uart8_rx_sync.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart8_rx_sync_pkg.sv
// Shared UART definitions: FSM state encodings, data width, default oversample,
// baud divider computation and the 3-sample majority vote. No latency, no backpressure.
package uart8_rx_sync_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_t;

  // Oversample divider: integer truncation, never below 1.
  function automatic int calc_div(input int clock_rate, input int baud_rate, input int oversample);
    int d;
    d = clock_rate / (baud_rate * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart8_rx_sync_if.sv
// Receiver-side signal bundle: serial input, enable, byte handshake and error pulses.
// Pure wiring, no latency; outValid/outReady carries the byte backpressure.
interface uart8_rx_sync_if;
  logic       en;
  logic       rx;
  logic       outReady;
  logic [7:0] outData;
  logic       outValid;
  logic       busy;
  logic       frameErr;
  logic       overrun;
  logic       parityErr;

  modport master (
    input  en, rx, outReady,
    output outData, outValid, busy, frameErr, overrun, parityErr
  );

  modport slave (
    output en, rx, outReady,
    input  outData, outValid, busy, frameErr, overrun, parityErr
  );
endinterface

// File: rtl/uart8_rx_sync_tick_gen.sv
// Oversample tick generator: free-running 0..DIV-1 counter, tick when it reads DIV-1, clearable.
// Tick is combinational from the counter register; no backpressure.
module uart_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_tick
);
  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (i_clr || r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_tick = (r_cnt == LAST);
endmodule

// File: rtl/uart8_rx_sync.sv
// 8N1 UART receiver, 16x oversampling with 3-sample majority; optional parity via UART8_RX_PARITY_EN.
// outValid rises 1 cycle after the stop-bit eval tick; a byte completing while outValid&&!outReady is dropped (overrun).
module uart8_rx_sync
  import uart8_rx_sync_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic             clk,
  input  logic             rst,
  uart8_rx_sync_if.master  bus
);
  localparam int             DIV     = calc_div(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
  localparam int             SCW     = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_V0   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] SC_V1   = SCW'(OVERSAMPLE / 2);
  localparam logic [SCW-1:0] SC_EVAL = SCW'(OVERSAMPLE / 2 + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);

  logic                 r_rx_meta;
  logic                 r_rxS;
  rx_state_t            r_state;
  logic [SCW-1:0]       r_sc;
  logic [2:0]           r_idx;
  logic [1:0]           r_vote;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_need_high;
  logic [DATA_BITS-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_busy;
  logic                 r_frame_err;
  logic                 r_overrun;
`ifdef UART8_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
`endif

  logic w_tick;
  logic w_clr;
  logic w_maj;
  logic w_eval;
  logic w_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rxS     <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rxS     <= r_rx_meta;
    end
  end

  // A start edge is ignored until the line has gone high again after a framing error (break).
  assign w_clr  = (r_state == ST_IDLE) && bus.en && !r_rxS && !r_need_high;
  assign w_maj  = maj3(r_vote[0], r_vote[1], r_rxS);
  assign w_eval = w_tick && (r_sc == SC_EVAL);
  assign w_wrap = w_tick && (r_sc == SC_LAST);

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sc         <= '0;
      r_idx        <= '0;
      r_vote       <= '0;
      r_shift      <= '0;
      r_need_high  <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef UART8_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART8_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
      if (r_out_valid && bus.outReady)
        r_out_valid <= 1'b0;
      if (r_rxS)
        r_need_high <= 1'b0;

      if (r_state != ST_IDLE && w_tick) begin
        if (r_sc == SC_V0) r_vote[0] <= r_rxS;
        if (r_sc == SC_V1) r_vote[1] <= r_rxS;
        r_sc <= (r_sc == SC_LAST) ? '0 : r_sc + SCW'(1);
      end

      if (!bus.en && r_state != ST_IDLE) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_clr) begin
              r_state <= ST_START;
              r_busy  <= 1'b1;
              r_sc    <= '0;
              r_idx   <= '0;
            end
          end
          ST_START: begin
            if (w_eval && w_maj) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end else if (w_wrap) begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (w_eval)
              r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
            if (w_wrap) begin
              r_idx <= r_idx + 3'd1;
              if (r_idx == 3'(DATA_BITS - 1))
`ifdef UART8_RX_PARITY_EN
                r_state <= ST_PARITY;
`else
                r_state <= ST_STOP;
`endif
            end
          end
`ifdef UART8_RX_PARITY_EN
          ST_PARITY: begin
            if (w_eval)
              r_par_bad <= ^{r_shift, w_maj};
            if (w_wrap)
              r_state <= ST_STOP;
          end
`endif
          ST_STOP: begin
            if (w_eval) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              if (!w_maj) begin
                r_frame_err <= 1'b1;
                r_need_high <= 1'b1;
              end
`ifdef UART8_RX_PARITY_EN
              r_parity_err <= r_par_bad;
              if (w_maj && !r_par_bad) begin
`else
              if (w_maj) begin
`endif
                // A same-cycle accept frees the holding register, so load instead of overrun.
                if (!r_out_valid || bus.outReady) begin
                  r_out_data  <= r_shift;
                  r_out_valid <= 1'b1;
                end else begin
                  r_overrun <= 1'b1;
                end
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.outData  = r_out_data;
  assign bus.outValid = r_out_valid;
  assign bus.busy     = r_busy;
  assign bus.frameErr = r_frame_err;
  assign bus.overrun  = r_overrun;
`ifdef UART8_RX_PARITY_EN
  assign bus.parityErr = r_parity_err;
`else
  assign bus.parityErr = 1'b0;
`endif
endmodule
